// File: rtl/seg7_reader.sv
// Reads a free-running 7-segment display bus, debounces it, decodes digits 0..7 and tracks counting steps.
// Define SEG7_READER_DOWN_EN to also accept single downward steps as legal.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       KEY0,
    input  logic [0:6] HEX_IN,
    input  logic       CLR_ERR,
    output logic [2:0] DIGIT,
    output logic       DIGIT_VALID,
    output logic       STEP,
    output logic [7:0] STEP_CNT,
    output logic       STEP_ERR,
    output logic       BAD_PAT
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [0:6] BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;

    state_t           state;
    logic [0:6]       sync1, sync2;
    logic [0:6]       cand, acc_pat;
    logic [CNT_W-1:0] stab_cnt;
    logic             armed;

    logic             accept_c;
    logic             dec_ok_c;
    logic             blank_c;
    logic             step_c;
    logic [2:0]       dec_c;

    // A candidate fires once after STABLE samples; armed blocks re-accepting the last accepted pattern.
    assign accept_c = armed && (stab_cnt == STABLE);

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            sync1    <= BLANK;
            sync2    <= BLANK;
            cand     <= BLANK;
            acc_pat  <= BLANK;
            stab_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            sync1 <= HEX_IN;
            sync2 <= sync1;
            if (accept_c) begin
                acc_pat <= cand;
                armed   <= 1'b0;
            end
            if (sync2 != cand) begin
                cand     <= sync2;
                stab_cnt <= CNT_W'(1);
                armed    <= (sync2 != (accept_c ? cand : acc_pat));
            end else if (stab_cnt < STABLE) begin
                stab_cnt <= stab_cnt + CNT_W'(1);
            end
        end
    end

    // Segment order a..g, active-low.
    always_comb begin
        dec_ok_c = 1'b1;
        dec_c    = 3'd0;
        blank_c  = (cand == BLANK);
        case (cand)
            7'b0000001: dec_c = 3'd0;
            7'b1001111: dec_c = 3'd1;
            7'b0010010: dec_c = 3'd2;
            7'b0000110: dec_c = 3'd3;
            7'b1001100: dec_c = 3'd4;
            7'b0100100: dec_c = 3'd5;
            7'b0100000: dec_c = 3'd6;
            7'b0001111: dec_c = 3'd7;
            default:    dec_ok_c = 1'b0;
        endcase
    end

`ifdef SEG7_READER_DOWN_EN
    assign step_c = (dec_c == 3'(DIGIT + 3'd1)) || (dec_c == 3'(DIGIT - 3'd1));
`else
    assign step_c = (dec_c == 3'(DIGIT + 3'd1));
`endif

    // Tracking FSM; clear wins over a same-edge acceptance.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state       <= IDLE;
            DIGIT       <= 3'd0;
            DIGIT_VALID <= 1'b0;
            STEP        <= 1'b0;
            STEP_CNT    <= 8'd0;
            STEP_ERR    <= 1'b0;
            BAD_PAT     <= 1'b0;
        end else begin
            STEP    <= 1'b0;
            BAD_PAT <= 1'b0;
            if (CLR_ERR) begin
                state       <= IDLE;
                STEP_ERR    <= 1'b0;
                STEP_CNT    <= 8'd0;
                DIGIT_VALID <= 1'b0;
            end else if (accept_c) begin
                if (blank_c) begin
                    DIGIT_VALID <= 1'b0;
                end else if (!dec_ok_c) begin
                    DIGIT_VALID <= 1'b0;
                    BAD_PAT     <= 1'b1;
                    STEP_ERR    <= 1'b1;
                    state       <= ERROR;
                end else begin
                    DIGIT       <= dec_c;
                    DIGIT_VALID <= 1'b1;
                    case (state)
                        IDLE: state <= TRACK;
                        TRACK: begin
                            if (step_c) begin
                                STEP <= 1'b1;
                                if (STEP_CNT != 8'hFF) begin
                                    STEP_CNT <= STEP_CNT + 8'd1;
                                end
                            end else if (dec_c != 3'd0) begin
                                STEP_ERR <= 1'b1;
                                state    <= ERROR;
                            end
                        end
                        ERROR: ;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed self-checking bench for seg7_reader (STABLE_CYCLES = 4).
module tb_seg7_reader;

    logic       CLOCK_50;
    logic       KEY0;
    logic [0:6] HEX_IN;
    logic       CLR_ERR;
    logic [2:0] DIGIT;
    logic       DIGIT_VALID;
    logic       STEP;
    logic [7:0] STEP_CNT;
    logic       STEP_ERR;
    logic       BAD_PAT;

    int n_checks = 0;
    int n_fail = 0;
    int step_pulses = 0;
    int bad_pulses = 0;
    int s0;
    int b0;

    seg7_reader #(.STABLE_CYCLES(4)) dut (
        .CLOCK_50   (CLOCK_50),
        .KEY0       (KEY0),
        .HEX_IN     (HEX_IN),
        .CLR_ERR    (CLR_ERR),
        .DIGIT      (DIGIT),
        .DIGIT_VALID(DIGIT_VALID),
        .STEP       (STEP),
        .STEP_CNT   (STEP_CNT),
        .STEP_ERR   (STEP_ERR),
        .BAD_PAT    (BAD_PAT)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Pulse counters read the value held during the preceding cycle.
    always @(posedge CLOCK_50) begin
        if (STEP) step_pulses++;
        if (BAD_PAT) bad_pulses++;
    end

    function automatic logic [0:6] seg(input int d);
        case (d)
            0: seg = 7'b0000001;
            1: seg = 7'b1001111;
            2: seg = 7'b0010010;
            3: seg = 7'b0000110;
            4: seg = 7'b1001100;
            5: seg = 7'b0100100;
            6: seg = 7'b0100000;
            7: seg = 7'b0001111;
            default: seg = 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [0:6] p, input int n);
        HEX_IN = p;
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic clr();
        CLR_ERR = 1'b1;
        @(negedge CLOCK_50);
        CLR_ERR = 1'b0;
        @(negedge CLOCK_50);
    endtask

    initial begin
        KEY0    = 1'b0;
        CLR_ERR = 1'b0;
        HEX_IN  = 7'b1111111;
        repeat (3) @(negedge CLOCK_50);
        check("rst_digit", 32'(DIGIT), 0);
        check("rst_valid", 32'(DIGIT_VALID), 0);
        check("rst_step", 32'(STEP), 0);
        check("rst_cnt", 32'(STEP_CNT), 0);
        check("rst_err", 32'(STEP_ERR), 0);
        check("rst_bad", 32'(BAD_PAT), 0);
        KEY0 = 1'b1;

        // Full count 0..7 then wrap to 0
        s0 = step_pulses;
        for (int d = 0; d <= 8; d++) begin
            hold(seg(d % 8), 10);
            check("walk_digit", 32'(DIGIT), 32'(d % 8));
        end
        check("walk_valid", 32'(DIGIT_VALID), 1);
        check("walk_pulses", 32'(step_pulses - s0), 8);
        check("walk_cnt", 32'(STEP_CNT), 8);
        check("walk_err", 32'(STEP_ERR), 0);

        // Glitch rejection and exact acceptance latency
        clr();
        check("clr_cnt", 32'(STEP_CNT), 0);
        check("clr_valid", 32'(DIGIT_VALID), 0);
        hold(seg(2), 3);
        hold(seg(0), 10);
        check("glitch_valid", 32'(DIGIT_VALID), 0);
        check("glitch_digit", 32'(DIGIT), 0);
        HEX_IN = seg(2);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLOCK_50);
            check("lat_early", 32'(DIGIT_VALID), 0);
        end
        @(negedge CLOCK_50);
        check("lat_digit", 32'(DIGIT), 2);
        check("lat_valid", 32'(DIGIT_VALID), 1);
        hold(seg(2), 4);

        // Illegal jump, frozen count in ERROR, clear
        s0 = step_pulses;
        hold(seg(3), 10);
        check("step3_cnt", 32'(STEP_CNT), 1);
        check("step3_pulse", 32'(step_pulses - s0), 1);
        s0 = step_pulses;
        hold(seg(5), 10);
        check("jump_err", 32'(STEP_ERR), 1);
        check("jump_digit", 32'(DIGIT), 5);
        check("jump_pulse", 32'(step_pulses - s0), 0);
        hold(seg(6), 10);
        check("errtrk_digit", 32'(DIGIT), 6);
        check("errtrk_cnt", 32'(STEP_CNT), 1);
        check("errtrk_pulse", 32'(step_pulses - s0), 0);
        clr();
        check("clr2_err", 32'(STEP_ERR), 0);
        check("clr2_cnt", 32'(STEP_CNT), 0);
        check("clr2_valid", 32'(DIGIT_VALID), 0);
        s0 = step_pulses;
        hold(seg(7), 10);
        check("idle_digit", 32'(DIGIT), 7);
        check("idle_valid", 32'(DIGIT_VALID), 1);
        check("idle_pulse", 32'(step_pulses - s0), 0);
        check("idle_err", 32'(STEP_ERR), 0);

        // Undecodable pattern, then blank
        b0 = bad_pulses;
        hold(7'b1111110, 10);
        check("bad_pulse", 32'(bad_pulses - b0), 1);
        check("bad_err", 32'(STEP_ERR), 1);
        check("bad_valid", 32'(DIGIT_VALID), 0);
        check("bad_digit", 32'(DIGIT), 7);
        hold(7'b1111111, 10);
        check("blank_pulse", 32'(bad_pulses - b0), 1);
        check("blank_err", 32'(STEP_ERR), 1);
        clr();

        // Counter reset to 0 observed while tracking
        hold(seg(4), 10);
        hold(seg(5), 10);
        check("c5_cnt", 32'(STEP_CNT), 1);
        s0 = step_pulses;
        hold(seg(0), 10);
        check("zero_digit", 32'(DIGIT), 0);
        check("zero_pulse", 32'(step_pulses - s0), 0);
        check("zero_err", 32'(STEP_ERR), 0);
        check("zero_cnt", 32'(STEP_CNT), 1);

        // Async reset in the middle of filtering
        HEX_IN = seg(3);
        repeat (3) @(negedge CLOCK_50);
        KEY0 = 1'b0;
        #1;
        check("arst_digit", 32'(DIGIT), 0);
        check("arst_valid", 32'(DIGIT_VALID), 0);
        check("arst_step", 32'(STEP), 0);
        check("arst_cnt", 32'(STEP_CNT), 0);
        check("arst_err", 32'(STEP_ERR), 0);
        check("arst_bad", 32'(BAD_PAT), 0);
        @(negedge CLOCK_50);
        KEY0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLOCK_50);
            check("arst_early", 32'(DIGIT_VALID), 0);
        end
        @(negedge CLOCK_50);
        check("arst_digit3", 32'(DIGIT), 3);
        check("arst_valid3", 32'(DIGIT_VALID), 1);

        // Downward step 0 -> 7
        hold(seg(0), 10);
        check("down_pre", 32'(DIGIT), 0);
        s0 = step_pulses;
        hold(seg(7), 10);
        check("down_digit", 32'(DIGIT), 7);
`ifdef SEG7_READER_DOWN_EN
        check("down_pulse", 32'(step_pulses - s0), 1);
        check("down_cnt", 32'(STEP_CNT), 1);
        check("down_err", 32'(STEP_ERR), 0);
`else
        check("down_pulse", 32'(step_pulses - s0), 0);
        check("down_cnt", 32'(STEP_CNT), 0);
        check("down_err", 32'(STEP_ERR), 1);
`endif

        // Step counter saturation
        clr();
        hold(seg(0), 8);
        for (int i = 1; i <= 260; i++) begin
            hold(seg(i % 8), 8);
        end
        check("sat_cnt", 32'(STEP_CNT), 255);
        check("sat_err", 32'(STEP_ERR), 0);
        check("sat_digit", 32'(DIGIT), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
